cacheline_mem_arbiter: RTL

- Shares the single physical-memory (L2/main memory) line port between the I-cache miss path and the D-cache miss/writeback path of the pipelined RV32I CPU.
- Sits below both caches. It grants one requester at a time and registers the granted command onto the memory port.
- Routes the memory response back to the owner only.
- Uses round-robin fairness, so neither fetch nor load/store starves the other.

---
 rtl/cacheline_mem_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache and D-cache miss paths.
// The granted command is registered onto the memory port; the response is routed to the owner only.
module cacheline_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_read_q, cmd_read_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // On a tie the side that did not win last time is granted (last_grant: 1 = data).
  assign grant_i = i_req & (~d_req | last_grant_q);
  assign grant_d = d_req & ~grant_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_read_d   = cmd_read_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = INST;
          last_grant_d = 1'b0;
          cmd_read_d   = 1'b1;
          cmd_write_d  = 1'b0;
          cmd_addr_d   = icache_address;
        end else if (grant_d) begin
          state_d      = DATA;
          last_grant_d = 1'b1;
          cmd_read_d   = ~dcache_write;
          cmd_write_d  = dcache_write;
          cmd_addr_d   = dcache_address;
          cmd_wdata_d  = dcache_wdata;
        end
      end
      INST, DATA: begin
        if (mem_resp) begin
          state_d     = IDLE;
          cmd_read_d  = 1'b0;
          cmd_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_read_d  = 1'b0;
        cmd_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_read_q   <= cmd_read_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  assign mem_read    = cmd_read_q;
  assign mem_write   = cmd_write_q;
  assign mem_address = cmd_addr_q;
  assign mem_wdata   = cmd_wdata_q;

  assign icache_resp  = mem_resp & (state_q == INST);
  assign dcache_resp  = mem_resp & (state_q == DATA);
  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

endmodule
